// File: rtl/spdif_pkg.sv
// ============================================================================
// spdif_pkg : shared S/PDIF channel-status constants, FSM state type, helpers
// Revision  : 1.0
// ============================================================================
`default_nettype none

package spdif_pkg;

  localparam int CS_WORD_BITS = 192;

  localparam int CS_CHNUM_LSB = 20;
  localparam int CS_CHNUM_MSB = 23;

  localparam logic [3:0] CS_CHNUM_LEFT  = 4'd1;
  localparam logic [3:0] CS_CHNUM_RIGHT = 4'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } cs_state_e;

  // Frames beyond the 192-bit word (only reachable with BLOCK_FRAMES > 192) send 0.
  function automatic logic cs_word_bit(input logic [CS_WORD_BITS-1:0] word,
                                       input logic [7:0]              idx);
    cs_word_bit = (idx < 8'(CS_WORD_BITS)) ? word[idx] : 1'b0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spdif_cs_sequencer.sv
// ============================================================================
// spdif_cs_sequencer : latches the 192-bit channel-status word once per block
// and serialises one bit per subframe (left, right) over a valid/ready link.
// Optional feature macro: SPDIF_CS_CHANNEL_NUM_EN (per-subframe channel number)
// Revision : 1.0
// ============================================================================
`default_nettype none

module spdif_cs_sequencer
  import spdif_pkg::*;
#(
  parameter int BLOCK_FRAMES = 192
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [CS_WORD_BITS-1:0] channelStatus,
  output logic                    csValid,
  input  logic                    csReady,
  output logic                    csBit,
  output logic                    blockStart,
  output logic                    isRight,
  output logic [7:0]              frameIndex,
  output logic                    blockDone
);

  localparam logic [7:0] LAST_FRAME = 8'(BLOCK_FRAMES - 1);

  cs_state_e               state;
  cs_state_e               state_n;
  logic [CS_WORD_BITS-1:0] shadow;
  logic [CS_WORD_BITS-1:0] word_src;
  logic [7:0]              frame_n;
  logic                    right_n;
  logic                    valid_n;
  logic                    done_n;
  logic                    start_n;
  logic                    bit_raw;
  logic                    bit_n;
  logic                    accept;

  assign accept = csValid & csReady;

  // In LOAD the shadow is being written this cycle, so the first bit comes
  // straight from the input word to keep csBit aligned with frameIndex.
  assign word_src = (state == LOAD) ? channelStatus : shadow;

  always_comb begin
    state_n = state;
    frame_n = frameIndex;
    right_n = isRight;
    valid_n = 1'b0;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        frame_n = 8'd0;
        right_n = 1'b0;
        if (enable) begin
          state_n = LOAD;
        end
      end

      LOAD: begin
        frame_n = 8'd0;
        right_n = 1'b0;
        valid_n = 1'b1;
        state_n = RUN;
      end

      RUN: begin
        valid_n = 1'b1;
        if (accept) begin
          if (!isRight) begin
            right_n = 1'b1;
          end else if (frameIndex < LAST_FRAME) begin
            right_n = 1'b0;
            frame_n = frameIndex + 8'd1;
          end else begin
            right_n = 1'b0;
            frame_n = 8'd0;
            valid_n = 1'b0;
            done_n  = 1'b1;
            state_n = LOAD;
          end
        end
      end

      default: begin
        state_n = IDLE;
        frame_n = 8'd0;
        right_n = 1'b0;
      end
    endcase

    // Dropping enable overrides any accept in the same cycle.
    if (!enable) begin
      state_n = IDLE;
      frame_n = 8'd0;
      right_n = 1'b0;
      valid_n = 1'b0;
      done_n  = 1'b0;
    end
  end

`ifdef SPDIF_CS_CHANNEL_NUM_EN
  logic [3:0] chnum;

  always_comb begin
    chnum = right_n ? CS_CHNUM_RIGHT : CS_CHNUM_LEFT;
    if ((frame_n >= 8'(CS_CHNUM_LSB)) && (frame_n <= 8'(CS_CHNUM_MSB))) begin
      bit_raw = chnum[2'(frame_n - 8'(CS_CHNUM_LSB))];
    end else begin
      bit_raw = cs_word_bit(word_src, frame_n);
    end
  end
`else
  assign bit_raw = cs_word_bit(word_src, frame_n);
`endif

  assign bit_n   = bit_raw & valid_n;
  assign start_n = valid_n & (frame_n == 8'd0) & ~right_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shadow     <= '0;
      csValid    <= 1'b0;
      csBit      <= 1'b0;
      blockStart <= 1'b0;
      isRight    <= 1'b0;
      frameIndex <= 8'd0;
      blockDone  <= 1'b0;
    end else begin
      state      <= state_n;
      csValid    <= valid_n;
      csBit      <= bit_n;
      blockStart <= start_n;
      isRight    <= right_n;
      frameIndex <= frame_n;
      blockDone  <= done_n;
      if (state == LOAD) begin
        shadow <= channelStatus;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spdif_cs_sequencer.sv
// ============================================================================
// tb_spdif_cs_sequencer : directed self-checking bench for spdif_cs_sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spdif_cs_sequencer;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [191:0] channelStatus;
  logic         csValid;
  logic         csReady;
  logic         csBit;
  logic         blockStart;
  logic         isRight;
  logic [7:0]   frameIndex;
  logic         blockDone;

  int n_checks;
  int n_errors;

  int m_fi;
  bit m_ir;
  bit m_done;

  spdif_cs_sequencer #(.BLOCK_FRAMES(192)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .channelStatus (channelStatus),
    .csValid       (csValid),
    .csReady       (csReady),
    .csBit         (csBit),
    .blockStart    (blockStart),
    .isRight       (isRight),
    .frameIndex    (frameIndex),
    .blockDone     (blockDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [191:0] w, input int fi, input bit ir);
    logic       b;
    logic [3:0] ch;
    b  = (fi < 192) ? w[fi] : 1'b0;
    ch = ir ? 4'd2 : 4'd1;
`ifdef SPDIF_CS_CHANNEL_NUM_EN
    if (fi >= 20 && fi <= 23) b = ch[fi-20];
`endif
    return b;
  endfunction

  // {csValid, blockStart, isRight, frameIndex, csBit, blockDone}
  function automatic logic [12:0] observed();
    return {csValid, blockStart, isRight, frameIndex, csBit, blockDone};
  endfunction

  function automatic logic [12:0] expected(input logic [191:0] w);
    return {1'b1, (m_fi == 0) && !m_ir, m_ir, 8'(m_fi), exp_bit(w, m_fi, m_ir), 1'b0};
  endfunction

  task automatic advance_model();
    if (!m_ir) begin
      m_ir = 1'b1;
    end else if (m_fi < 191) begin
      m_ir = 1'b0;
      m_fi++;
    end else begin
      m_done = 1'b1;
    end
  endtask

  // Called on the first RUN cycle of a block; returns on the cycle after the final accept.
  task automatic run_block(input string tag, input logic [191:0] w, input bit rnd,
                           input int change_at, input logic [191:0] new_cs);
    int budget;
    m_fi = 0; m_ir = 1'b0; m_done = 1'b0;
    budget = 0;
    while (!m_done && budget < 4000) begin
      csReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_fi == change_at) channelStatus = new_cs;
      check(tag, observed(), expected(w));
      step();
      if (csReady) advance_model();
      budget++;
    end
    if (!m_done) check({tag, "_timeout"}, 0, 1);
    check({tag, "_done"}, {csValid, blockDone}, 2'b01);
  endtask

  task automatic advance_to(input string tag, input logic [191:0] w, input int target);
    int budget;
    m_fi = 0; m_ir = 1'b0; m_done = 1'b0;
    budget = 0;
    while (!(m_fi == target && !m_ir) && budget < 1000) begin
      csReady = 1'b1;
      check(tag, observed(), expected(w));
      step();
      advance_model();
      budget++;
    end
    if (budget >= 1000) check({tag, "_timeout"}, 0, 1);
  endtask

  logic [191:0] w_chg;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    enable = 1'b0;
    csReady = 1'b0;
    channelStatus = '0;
    step();
    step();
    check("reset_outputs", observed(), 13'd0);

    // Bit 0 only, always ready
    reset = 1'b0;
    channelStatus = 192'h1;
    enable = 1'b1;
    csReady = 1'b1;
    step();
    check("latency_load", csValid, 1'b0);
    step();
    check("latency_run", csValid, 1'b1);
    run_block("blk_bit0", 192'h1, 1'b0, -1, '0);
    step();
    check("restart_after_bubble", observed(), {1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0});

    // Reload with 0x5A under random backpressure
    enable = 1'b0;
    step();
    check("abort_idle", observed(), 13'd0);
    channelStatus = 192'h5A;
    enable = 1'b1;
    step();
    step();
    run_block("blk_5a", 192'h5A, 1'b1, -1, '0);
    step();

    // Mid-block word change takes effect only at the next block
    w_chg = 192'h5A;
    w_chg[191] = 1'b1;
    run_block("blk_chg_old", 192'h5A, 1'b0, 100, w_chg);
    step();
    run_block("blk_chg_new", w_chg, 1'b0, -1, '0);
    step();

    // Drop enable with a pending, un-accepted subframe
    advance_to("pre_abort", w_chg, 50);
    csReady = 1'b0;
    check("pending_valid", {csValid, frameIndex}, {1'b1, 8'd50});
    enable = 1'b0;
    step();
    check("abort_outputs", observed(), 13'd0);
    enable = 1'b1;
    step();
    check("reenable_load", {csValid, blockDone}, 2'b00);
    step();
    check("reenable_start", observed(), {1'b1, 1'b1, 1'b0, 8'd0, exp_bit(w_chg, 0, 1'b0), 1'b0});

    // Reset coincident with an accept
    advance_to("pre_reset", w_chg, 150);
    csReady = 1'b1;
    reset = 1'b1;
    step();
    check("reset_midblock", observed(), 13'd0);
    reset = 1'b0;
    step();
    check("post_reset_idle", {csValid, blockDone}, 2'b00);
    step();
    check("post_reset_run", {csValid, blockStart}, 2'b11);

    // All-zero word: only the channel-number field (if enabled) is non-zero
    enable = 1'b0;
    channelStatus = '0;
    step();
    enable = 1'b1;
    step();
    step();
    run_block("blk_zero", '0, 1'b0, -1, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
